// File: rtl/mem_types_pkg.sv
// Shared types for the CPU-to-RAM word interface.
// Holds the bus status encoding and the responder FSM states.
package mem_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } ram_responder_state_t;

  localparam int WORD_W = 32;

  // Counter width needed to reach lat; never below one bit so LAT=0 still elaborates.
  function automatic int cntWidth(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/ram_word_array.sv
// Word-wide storage behind the RAM responder.
// Asynchronous read, synchronous write, contents are never reset.
module ram_word_array
  import mem_types_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ram_responder.sv
// RAM side of the CPU-to-RAM word interface with a configurable access latency.
// Requests are held BUSY for LAT cycles, then complete in a single ACCESS cycle.
module ram_responder
  import mem_types_pkg::*;
#(
  parameter int LAT    = 2,
  parameter int ADDR_W = 14
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [1:0]  ramstate,
  output logic [31:0] ramload
);

  localparam int CNT_W = cntWidth(LAT);
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  ram_responder_state_t state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]    latAddr_q, latAddr_d;
  logic                 latWe_q, latWe_d;
  logic [31:0]          latData_q, latData_d;

  logic              req;
  logic              illegal;
  logic              changed;
  logic [ADDR_W-1:0] reqAddr;
  ramstate_t         stateOut;
  logic              memWe;
  logic [ADDR_W-1:0] memWaddr;
  logic [31:0]       memWdata;
  logic [ADDR_W-1:0] memRaddr;
  logic [31:0]       memRdata;
  logic              readHit;

  assign req     = ramREN | ramWEN;
  assign reqAddr = ramaddr[ADDR_W+1:2];
  assign illegal = req & ((ramREN & ramWEN) | (ramaddr[1:0] != 2'b00) |
                          ((ramaddr >> (ADDR_W + 2)) != 32'd0));
  assign changed = (latWe_q != ramWEN) || (latAddr_q != reqAddr) ||
                   (ramWEN && (latData_q != ramstore));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latAddr_d = latAddr_q;
    latWe_d   = latWe_q;
    latData_d = latData_q;
    stateOut  = FREE;
    memWe     = 1'b0;
    memWaddr  = latAddr_q;
    memWdata  = latData_q;
    memRaddr  = latAddr_q;
    readHit   = 1'b0;

    if (illegal) begin
      stateOut  = ERROR;
      state_d   = IDLE;
      cnt_d     = '0;
      latAddr_d = '0;
      latWe_d   = 1'b0;
      latData_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (LAT == 0) begin
              // Zero latency completes straight from the live bus inputs.
              stateOut = ACCESS;
              memWaddr = reqAddr;
              memWdata = ramstore;
              memRaddr = reqAddr;
              memWe    = ramWEN;
              readHit  = ramREN;
            end else begin
              stateOut  = BUSY;
              latAddr_d = reqAddr;
              latWe_d   = ramWEN;
              latData_d = ramstore;
              cnt_d     = ONE_C;
              state_d   = WAIT;
            end
          end
        end
        WAIT: begin
          if (!req) begin
            stateOut = FREE;
            state_d  = IDLE;
          end else if (changed) begin
            // Any edit to the held request restarts the full latency.
            stateOut  = BUSY;
            latAddr_d = reqAddr;
            latWe_d   = ramWEN;
            latData_d = ramstore;
            cnt_d     = ONE_C;
          end else if (cnt_q == LAT_C) begin
            stateOut = ACCESS;
            memWe    = latWe_q;
            readHit  = ~latWe_q;
            state_d  = IDLE;
          end else begin
            stateOut = BUSY;
            cnt_d    = cnt_q + ONE_C;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Reset held low masks everything, including a write about to commit.
    if (!nRST) begin
      stateOut = FREE;
      memWe    = 1'b0;
      readHit  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      latAddr_q <= '0;
      latWe_q   <= 1'b0;
      latData_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      latAddr_q <= latAddr_d;
      latWe_q   <= latWe_d;
      latData_q <= latData_d;
    end
  end

  ram_word_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk_i  (CLK),
    .we_i   (memWe),
    .waddr_i(memWaddr),
    .wdata_i(memWdata),
    .raddr_i(memRaddr),
    .rdata_o(memRdata)
  );

  assign ramstate = stateOut;
  assign ramload  = readHit ? memRdata : 32'h0;

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder at LAT=2, LAT=0 and LAT=3.
// Stimulus queues the expected bus status per cycle; a negedge monitor pops and compares.
module tb_ram_responder;
  import mem_types_pkg::*;

  typedef struct {
    int          id;
    logic [1:0]  st;
    logic [31:0] ld;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        nRst;
  logic        ren   [3];
  logic        wen   [3];
  logic [31:0] addr  [3];
  logic [31:0] store [3];
  logic [1:0]  st    [3];
  logic [31:0] load  [3];

  exp_t sb[$];
  exp_t monItem;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ram_responder #(.LAT(2), .ADDR_W(14)) dut0 (
    .CLK(clk), .nRST(nRst), .ramREN(ren[0]), .ramWEN(wen[0]),
    .ramaddr(addr[0]), .ramstore(store[0]), .ramstate(st[0]), .ramload(load[0])
  );

  ram_responder #(.LAT(0), .ADDR_W(14)) dut1 (
    .CLK(clk), .nRST(nRst), .ramREN(ren[1]), .ramWEN(wen[1]),
    .ramaddr(addr[1]), .ramstore(store[1]), .ramstate(st[1]), .ramload(load[1])
  );

  ram_responder #(.LAT(3), .ADDR_W(14)) dut2 (
    .CLK(clk), .nRST(nRst), .ramREN(ren[2]), .ramWEN(wen[2]),
    .ramaddr(addr[2]), .ramstore(store[2]), .ramstate(st[2]), .ramload(load[2])
  );

  task automatic checkOutput(input string nm, input logic [1:0] aSt, input logic [31:0] aLd,
                             input logic [1:0] eSt, input logic [31:0] eLd);
    checks++;
    if (aSt !== eSt || aLd !== eLd) begin
      errors++;
      $display("[TB] FAIL %s: got state %0d load %h, expected state %0d load %h",
               nm, aSt, aLd, eSt, eLd);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      monItem = sb.pop_front();
      checkOutput(monItem.name, st[monItem.id], load[monItem.id], monItem.st, monItem.ld);
    end
  end

  task automatic applyStimulus(input int id, input logic r, input logic w,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [1:0] eSt, input logic [31:0] eLd,
                               input string nm);
    @(posedge clk);
    #1;
    ren[id]   = r;
    wen[id]   = w;
    addr[id]  = a;
    store[id] = d;
    sb.push_back('{id: id, st: eSt, ld: eLd, name: nm});
  endtask

  task automatic idleCycle(input int id);
    applyStimulus(id, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, "idle");
  endtask

  task automatic doWrite(input int id, input int lat, input logic [31:0] a,
                         input logic [31:0] d, input string nm);
    for (int i = 0; i < lat; i++) applyStimulus(id, 1'b0, 1'b1, a, d, BUSY, 32'h0, nm);
    applyStimulus(id, 1'b0, 1'b1, a, d, ACCESS, 32'h0, nm);
  endtask

  task automatic doRead(input int id, input int lat, input logic [31:0] a,
                        input logic [31:0] expD, input string nm);
    for (int i = 0; i < lat; i++) applyStimulus(id, 1'b1, 1'b0, a, 32'h0, BUSY, 32'h0, nm);
    applyStimulus(id, 1'b1, 1'b0, a, 32'h0, ACCESS, expD, nm);
  endtask

  initial begin
    nRst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ren[i] = 1'b0; wen[i] = 1'b0; addr[i] = 32'h0; store[i] = 32'h0;
    end

    // Reset state, including a request held while reset is low.
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, "resetIdle");
    applyStimulus(0, 1'b1, 1'b0, 32'h40, 32'h0, FREE, 32'h0, "resetHeldReq");
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, "resetRelease");
    nRst = 1'b1;
    idleCycle(0);

    // LAT=2 write then read back.
    doWrite(0, 2, 32'h40, 32'hDEADBEEF, "lat2Write40");
    doRead(0, 2, 32'h40, 32'hDEADBEEF, "lat2Read40");
    idleCycle(0);

    // LAT=0 alternating writes and reads every cycle.
    doWrite(1, 0, 32'h0, 32'h1, "lat0Write0");
    doRead(1, 0, 32'h0, 32'h1, "lat0Read0");
    doWrite(1, 0, 32'h0, 32'h1, "lat0Write0b");
    doRead(1, 0, 32'h0, 32'h1, "lat0Read0b");
    doWrite(1, 0, 32'h4, 32'h22, "lat0Write4");
    doRead(1, 0, 32'h4, 32'h22, "lat0Read4");
    idleCycle(1);

    // LAT=3 address switch in the second BUSY cycle restarts the latency.
    doWrite(2, 3, 32'h10, 32'hAAAA1010, "lat3Write10");
    idleCycle(2);
    doWrite(2, 3, 32'h14, 32'hBBBB1414, "lat3Write14");
    idleCycle(2);
    applyStimulus(2, 1'b1, 1'b0, 32'h10, 32'h0, BUSY, 32'h0, "switchFirst");
    applyStimulus(2, 1'b1, 1'b0, 32'h14, 32'h0, BUSY, 32'h0, "switchChanged");
    applyStimulus(2, 1'b1, 1'b0, 32'h14, 32'h0, BUSY, 32'h0, "switchWait2");
    applyStimulus(2, 1'b1, 1'b0, 32'h14, 32'h0, BUSY, 32'h0, "switchWait3");
    applyStimulus(2, 1'b1, 1'b0, 32'h14, 32'h0, ACCESS, 32'hBBBB1414, "switchAccess");
    idleCycle(2);

    // Dropped write after one BUSY cycle leaves memory untouched.
    doWrite(0, 2, 32'h20, 32'h77, "initWrite20");
    idleCycle(0);
    applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'h5, BUSY, 32'h0, "abortBusy");
    idleCycle(0);
    doRead(0, 2, 32'h20, 32'h77, "abortRead20");
    idleCycle(0);

    // Illegal requests raise ERROR and never write.
    doWrite(0, 2, 32'h44, 32'h11, "initWrite44");
    idleCycle(0);
    doWrite(0, 2, 32'h0, 32'h55, "initWrite0");
    idleCycle(0);
    applyStimulus(0, 1'b1, 1'b1, 32'h44, 32'h99, ERROR, 32'h0, "illegalBoth");
    idleCycle(0);
    applyStimulus(0, 1'b0, 1'b1, 32'h42, 32'h99, ERROR, 32'h0, "illegalAlign");
    idleCycle(0);
    applyStimulus(0, 1'b0, 1'b1, 32'h00010000, 32'h99, ERROR, 32'h0, "illegalRange");
    idleCycle(0);
    applyStimulus(0, 1'b0, 1'b1, 32'h44, 32'h99, BUSY, 32'h0, "illegalMidBusy");
    applyStimulus(0, 1'b0, 1'b1, 32'h46, 32'h99, ERROR, 32'h0, "illegalMidWait");
    idleCycle(0);
    doRead(0, 2, 32'h44, 32'h11, "noWrite44");
    idleCycle(0);
    doRead(0, 2, 32'h40, 32'hDEADBEEF, "noWrite40");
    idleCycle(0);
    doRead(0, 2, 32'h0, 32'h55, "noWrite0");
    idleCycle(0);

    // Reset asserted during the BUSY cycle of a write discards it.
    doWrite(0, 2, 32'h30, 32'h3, "initWrite30");
    idleCycle(0);
    applyStimulus(0, 1'b0, 1'b1, 32'h30, 32'hA, BUSY, 32'h0, "rstBusy");
    @(negedge clk);
    #1;
    nRst = 1'b0;
    #1;
    checkOutput("rstImmediate", st[0], load[0], FREE, 32'h0);
    applyStimulus(0, 1'b0, 1'b1, 32'h30, 32'hA, FREE, 32'h0, "rstHeld");
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, "rstDrop");
    nRst = 1'b1;
    doRead(0, 2, 32'h30, 32'h3, "rstRead30");
    idleCycle(0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0 pending", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
# ram_responder

Responder end of the CPU-to-RAM word interface (`cpu_ram_if` `ram` side). It accepts single-word read or write requests from the memory controller or the testbench mux, holds them for a configurable latency while reporting `BUSY`, then completes them in exactly one `ACCESS` cycle. It replaces the fixed-behaviour RAM in simulation and latency sweeps, so controller and cache stall paths can be exercised at any `LAT`.

## Interface
- `LAT`, default 2: wait cycles between request acceptance and `ACCESS`. 0 is legal.
- `ADDR_W`, default 14: word-index bits; depth is 2^`ADDR_W` words.
- `CLK` input 1: single clock, rising edge.
- `nRST` input 1: reset, asynchronous, active-low.
- `ramREN` input 1: read request, held by the requester until `ACCESS`.
- `ramWEN` input 1: write request, held until `ACCESS`.
- `ramaddr` input 32: byte address, word aligned.
- `ramstore` input 32: write data.
- `ramstate` output 2: `ramstate_t` status (`FREE`, `BUSY`, `ACCESS`, `ERROR`), combinational from state and inputs.
- `ramload` output 32: read data. Valid only when `ramstate`==`ACCESS` and the request is a read; otherwise 32'h0.

## Operation
- A request is `ramREN|ramWEN`.
- A request is illegal if any of these hold:
  - `ramREN&ramWEN`
  - `ramaddr[1:0]`!=0
  - `ramaddr[31:ADDR_W+2]`!=0
- An illegal request:
  - drives `ERROR` that cycle;
  - moves the FSM to `IDLE`;
  - clears the latched request;
  - performs no write.
- FSM states are `IDLE` and `WAIT`, with counter `cnt` of width $clog2(`LAT`+1) (min 1). The latched request is `lat_addr`, `lat_we`, `lat_data`.
- `IDLE`, no request: `FREE`.
- `IDLE`, legal request:
  - `LAT`==0: `ACCESS` this cycle. A read drives `mem[ramaddr[ADDR_W+1:2]]`; a write commits on the closing edge. Stay `IDLE`.
  - `LAT`>0: `BUSY`, latch the request, `cnt`<=1, go to `WAIT`.
- `WAIT`, request dropped: `FREE`, go to `IDLE`. Abort; no write.
- `WAIT`, request changed (address, direction, or `ramstore` on a write, differs from the latched values): `BUSY`, re-latch, `cnt`<=1. The full latency restarts.
- `WAIT`, unchanged and `cnt`==`LAT`:
  - `ACCESS`; a read drives `mem[lat_addr]`, a write commits `lat_data` on the closing edge;
  - go to `IDLE`.
- `WAIT`, unchanged and `cnt`<`LAT`: `BUSY`, `cnt`<=`cnt`+1.
- A request still held in the cycle after `ACCESS` is a new request and pays full latency again.
- Memory contents are not reset; the bench initialises them by writing.

## Timing
- Reset (async assert, sync-clean deassert):
  - state `IDLE`, `cnt`=0, latched fields 0;
  - `ramstate`=`FREE`, `ramload`=0;
  - a pending write is discarded.
- Request first seen in cycle t with `LAT`=N:
  - `BUSY` in t..t+N-1;
  - `ACCESS` in t+N;
  - write visible to a read whose `ACCESS` is at t+N+1 or later.
- Back-to-back held requests complete every N+1 cycles.
- A read after a write to the same address returns the new data; there is no bypass hazard because the write commits before the next `ACCESS`.
- Reset mid-`WAIT` aborts the request; no partial write occurs.

## Structure
- `ramstate_t` comes from `mem_types_pkg` and is not redefined here.
- Add `ram_responder_state_t` (`IDLE`, `WAIT`) to `mem_types_pkg`.
- Sub-module `ram_word_array`: 2^`ADDR_W` x 32, asynchronous read, synchronous write enable; no reset.
- The FSM, counter and request latch live in the top module.

## Test plan
- `LAT`=2, write 32'hDEADBEEF to 0x40, then read 0x40 → `BUSY`,`BUSY`,`ACCESS` for each. Read `ACCESS` shows `ramload`=32'hDEADBEEF; `ramload`=0 in every `BUSY` cycle.
- `LAT`=0, alternate write 0x0=32'h1 and read 0x0 every cycle → `ACCESS` every cycle, never `BUSY`. Each read returns 32'h1.
- `LAT`=3, read 0x10, switch `ramaddr` to 0x14 in the second `BUSY` cycle → `ACCESS` 3 cycles after the switch, with `ramload`=`mem[0x14]`.
- `LAT`=2, write 0x20=32'h5, drop `ramWEN` after one `BUSY` cycle → `FREE` next cycle. A later read of 0x20 returns its previous value.
- Illegal requests each give `ERROR` and leave no write: `ramREN`&`ramWEN`; `ramaddr`=0x42; `ramaddr`=0x00010000 with `ADDR_W`=14.
- Assert `nRST` low in the `BUSY` cycle of a write 0x30=32'hA → `FREE` and `ramload`=0 immediately. A read of 0x30 after reset does not return 32'hA.
